// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters (CPU, debug/loader), the arbiter and the data memory.
// The slave modport is the arbiter's view; master is the environment (requesters + memory).
interface dmem_arbiter_if;
  logic       cpu_req;
  logic       cpu_we;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_gnt;
  logic       cpu_rvalid;
  logic [7:0] cpu_rdata;

  logic       dbg_req;
  logic       dbg_we;
  logic [3:0] dbg_addr;
  logic [7:0] dbg_wdata;
  logic       dbg_gnt;
  logic       dbg_rvalid;
  logic [7:0] dbg_rdata;

  logic       mem_en;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU has priority, debug port is guaranteed a slot after
// CPU_MAX_BURST consecutive CPU grants while it waits. Zero-latency grants, 1-cycle read return.
module dmem_arbiter #(
  parameter int CPU_MAX_BURST = 4
) (
  input logic         clk,
  input logic         reset,
  dmem_arbiter_if.slave bus
);

  localparam logic [2:0] MAX_STREAK = 3'(CPU_MAX_BURST);

  // Index 0 = CPU, index 1 = debug port.
  logic [1:0] req;
  logic [1:0] we;
  logic [3:0] addr  [2];
  logic [7:0] wdata [2];
  logic [1:0] gnt;
  logic [1:0] rvalid;
  logic [7:0] rdata [2];

  logic [2:0] streak_reg, streak_next;
  logic       rd_pending_reg, rd_pending_next;
  logic       rd_owner_reg, rd_owner_next;

  assign req      = {bus.dbg_req, bus.cpu_req};
  assign we       = {bus.dbg_we, bus.cpu_we};
  assign addr[0]  = bus.cpu_addr;
  assign addr[1]  = bus.dbg_addr;
  assign wdata[0] = bus.cpu_wdata;
  assign wdata[1] = bus.dbg_wdata;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_reg     <= 3'd0;
      rd_pending_reg <= 1'b0;
      rd_owner_reg   <= 1'b0;
    end else begin
      streak_reg     <= streak_next;
      rd_pending_reg <= rd_pending_next;
      rd_owner_reg   <= rd_owner_next;
    end
  end

  // Grant decision; forced idle while reset is held so nothing leaks onto the bus.
  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (streak_reg < MAX_STREAK) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    streak_next     = streak_reg;
    rd_pending_next = 1'b0;
    rd_owner_next   = rd_owner_reg;
    if (gnt[1] || !req[1]) begin
      streak_next = 3'd0;
    end else if (gnt[0]) begin
      streak_next = streak_reg + 3'd1;
    end
    if (gnt[0]) begin
      rd_pending_next = !we[0];
      rd_owner_next   = 1'b0;
    end else if (gnt[1]) begin
      rd_pending_next = !we[1];
      rd_owner_next   = 1'b1;
    end
  end

  // Memory-side outputs: follow the granted port, all zero when idle.
  always_comb begin
    bus.mem_en    = |gnt;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 4'd0;
    bus.mem_wdata = 8'd0;
    if (gnt[0]) begin
      bus.mem_we    = we[0];
      bus.mem_addr  = addr[0];
      bus.mem_wdata = wdata[0];
    end else if (gnt[1]) begin
      bus.mem_we    = we[1];
      bus.mem_addr  = addr[1];
      bus.mem_wdata = wdata[1];
    end
  end

  // Read return: only the registered owner sees data, everyone else reads zero.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    assign rvalid[gi] = rd_pending_reg && (rd_owner_reg == 1'(gi));
    assign rdata[gi]  = rvalid[gi] ? bus.mem_rdata : 8'h00;
  end

  assign bus.cpu_gnt    = gnt[0];
  assign bus.dbg_gnt    = gnt[1];
  assign bus.cpu_rvalid = rvalid[0];
  assign bus.dbg_rvalid = rvalid[1];
  assign bus.cpu_rdata  = rdata[0];
  assign bus.dbg_rdata  = rdata[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: stimulus pushes hand-computed grant/read expectations into queues,
// a negedge monitor pops and compares them against the bus every cycle.
module tb_dmem_arbiter;

  typedef struct {
    int         cyc;
    bit         port;
    bit         we;
    logic [3:0] addr;
    logic [7:0] wdata;
  } gnt_t;

  typedef struct {
    int         cyc;
    bit         port;
    logic [7:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  bit   done = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  gnt_t gq[$];
  rd_t  rq[$];

  logic [7:0] mem [16] = '{1: 8'h11, 2: 8'h22, 3: 8'h5A, default: 8'h00};

  dmem_arbiter_if bus ();

  dmem_arbiter #(.CPU_MAX_BURST(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read data memory.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  initial bus.mem_rdata = 8'h00;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!done) begin
      if (bus.cpu_gnt || bus.dbg_gnt || (gq.size() > 0 && gq[0].cyc <= cyc)) begin
        if (gq.size() == 0) begin
          chk("grant_unexpected", {bus.cpu_gnt, bus.dbg_gnt}, 0);
        end else begin
          gnt_t e;
          e = gq.pop_front();
          chk("grant_cycle", cyc, e.cyc);
          chk("grant_bus",
              {bus.cpu_gnt, bus.dbg_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata},
              {!e.port, e.port, 1'b1, e.we, e.addr, e.wdata});
        end
      end else begin
        chk("idle_bus",
            {bus.cpu_gnt, bus.dbg_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
      end

      if (bus.cpu_rvalid || bus.dbg_rvalid || (rq.size() > 0 && rq[0].cyc <= cyc)) begin
        if (rq.size() == 0) begin
          chk("rvalid_unexpected", {bus.cpu_rvalid, bus.dbg_rvalid}, 0);
        end else begin
          rd_t r;
          r = rq.pop_front();
          chk("rvalid_cycle", cyc, r.cyc);
          chk("read_return",
              {bus.cpu_rvalid, bus.dbg_rvalid, bus.cpu_rdata, bus.dbg_rdata},
              r.port ? {1'b0, 1'b1, 8'h00, r.data} : {1'b1, 1'b0, r.data, 8'h00});
        end
      end else begin
        chk("idle_read",
            {bus.cpu_rvalid, bus.dbg_rvalid, bus.cpu_rdata, bus.dbg_rdata}, 0);
      end
    end else begin
      chk("grant_queue_drained", gq.size(), 0);
      chk("read_queue_drained", rq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit creq, bit cwe, logic [3:0] caddr, logic [7:0] cwd,
                       bit dreq, bit dwe, logic [3:0] daddr, logic [7:0] dwd);
    bus.cpu_req   = creq;
    bus.cpu_we    = cwe;
    bus.cpu_addr  = caddr;
    bus.cpu_wdata = cwd;
    bus.dbg_req   = dreq;
    bus.dbg_we    = dwe;
    bus.dbg_addr  = daddr;
    bus.dbg_wdata = dwd;
  endtask

  task automatic idle();
    drive(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
  endtask

  // Expect a grant this cycle; a read also expects its data on the following cycle.
  task automatic expect_gnt(bit port, bit we, logic [3:0] addr, logic [7:0] wdata,
                            logic [7:0] rd, bit rd_expected = 1'b1);
    gnt_t g;
    rd_t  r;
    g.cyc = cyc; g.port = port; g.we = we; g.addr = addr; g.wdata = wdata;
    gq.push_back(g);
    if (!we && rd_expected) begin
      r.cyc = cyc + 1; r.port = port; r.data = rd;
      rq.push_back(r);
    end
  endtask

  task automatic both_write(bit exp_port);
    drive(1, 1, 4'd4, 8'hC4, 1, 1, 4'd5, 8'hD5);
    if (exp_port) expect_gnt(1, 1, 4'd5, 8'hD5, 8'h00);
    else          expect_gnt(0, 1, 4'd4, 8'hC4, 8'h00);
  endtask

  initial begin
    logic [0:9] pat_burst;
    logic [0:7] pat_drop;
    pat_burst = 10'b0000100001;
    pat_drop  = 8'b00000001;

    idle();
    next_cycle();
    // Requests held high during reset must not reach the bus.
    drive(1, 0, 4'd3, 8'h00, 1, 1, 4'd7, 8'h77);
    next_cycle();

    // First cycle out of reset: single CPU read of preloaded word.
    reset = 1'b0;
    drive(1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00);
    expect_gnt(0, 0, 4'd3, 8'h00, 8'h5A);
    next_cycle(); idle();

    // Debug write, then CPU reads it back.
    next_cycle();
    drive(0, 0, 4'd0, 8'h00, 1, 1, 4'd9, 8'hA7);
    expect_gnt(1, 1, 4'd9, 8'hA7, 8'h00);
    next_cycle();
    drive(1, 0, 4'd9, 8'h00, 0, 0, 4'd0, 8'h00);
    expect_gnt(0, 0, 4'd9, 8'h00, 8'hA7);

    // Back-to-back reads from different owners.
    next_cycle();
    drive(1, 0, 4'd1, 8'h00, 0, 0, 4'd0, 8'h00);
    expect_gnt(0, 0, 4'd1, 8'h00, 8'h11);
    next_cycle();
    drive(0, 0, 4'd0, 8'h00, 1, 0, 4'd2, 8'h00);
    expect_gnt(1, 0, 4'd2, 8'h00, 8'h22);

    // Read then same-address write: read returns old data, next read sees new.
    next_cycle();
    drive(1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00);
    expect_gnt(0, 0, 4'd3, 8'h00, 8'h5A);
    next_cycle();
    drive(0, 0, 4'd0, 8'h00, 1, 1, 4'd3, 8'hE3);
    expect_gnt(1, 1, 4'd3, 8'hE3, 8'h00);
    next_cycle();
    drive(1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00);
    expect_gnt(0, 0, 4'd3, 8'h00, 8'hE3);
    next_cycle(); idle();

    // Continuous contention: C,C,C,C,D repeating.
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      both_write(pat_burst[i]);
    end
    next_cycle(); idle();

    // Debug dropping its request clears the streak.
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      if (i == 2) begin
        drive(1, 1, 4'd4, 8'hC4, 0, 0, 4'd0, 8'h00);
        expect_gnt(0, 1, 4'd4, 8'hC4, 8'h00);
      end else begin
        both_write(pat_drop[i]);
      end
    end
    next_cycle(); idle();

    // Reset pulsed after a granted CPU read: its rvalid must never appear.
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      both_write(1'b0);
    end
    next_cycle();
    drive(1, 0, 4'd1, 8'h00, 1, 1, 4'd5, 8'hD5);
    expect_gnt(0, 0, 4'd1, 8'h00, 8'h00, 1'b0);
    #6 reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    drive(0, 0, 4'd0, 8'h00, 1, 0, 4'd2, 8'h00);
    expect_gnt(1, 0, 4'd2, 8'h00, 8'h22);
    next_cycle(); idle();

    // Reset clears a streak of 3: afterwards four CPU grants precede the debug slot.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      both_write(1'b0);
    end
    #6 reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    both_write(1'b0);
    for (int i = 1; i < 5; i++) begin
      next_cycle();
      both_write(i == 4);
    end
    next_cycle(); idle();

    // Idle: ten cycles with no requests.
    repeat (10) next_cycle();
    next_cycle();
    done = 1'b1;
    repeat (5) @(negedge clk);
    $display("FAIL monitor_finish: monitor did not end the run");
    $fatal(1);
  end

endmodule
